// File: rtl/m_wishbonereg_bank.sv
// Wishbone test register bank: NREG byte-writable registers, a push/pop FIFO
// mailbox drained by a consumer port, and a status register with sticky errors.
module m_wishbonereg_bank #(
  parameter  int NREG  = 4,
  parameter  int DW    = 32,
  parameter  int WAIT  = 0,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(NREG) + 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [AW-1:0]   ADR_I,
  input  logic [DW/8-1:0] SEL_I,
  input  logic [DW-1:0]   DAT_I,
  output logic            ACK_O,
  output logic [DW-1:0]   DAT_O,
  output logic [DW-1:0]   q_dat,
  output logic            q_vld,
  input  logic            q_rdy,
  output logic            irq
);
  localparam int LW = AW - 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] WLAST = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 wcnt_q, wcnt_d;
  logic                       commit;
  logic [NREG-1:0][DW-1:0]    regs_q;
  logic [DW-1:0]              mem_q [DEPTH];
  logic [PW-1:0]              rp_q, wp_q, rp_b;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ovf_q, unf_q, irq_q;
  logic [DW-1:0]              dat_q, rdata, stat;

  logic [LW-1:0] lo;
  logic is_reg, is_fifo, is_stat;
  logic empty, full, bpush, bpop, bpop_ok, cpop_ok, push_ok, stat_wr;

  // Bus handshake: side effects happen only on the edge that enters S_ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (STB_I) begin
        if (WAIT == 0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (!STB_I) state_d = S_IDLE;
        else if (wcnt_q == WLAST) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else wcnt_d = wcnt_q + 3'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lo      = ADR_I[LW-1:0];
  assign is_reg  = ~ADR_I[AW-1];
  assign is_fifo = ADR_I[AW-1] && (lo == LW'(0));
  assign is_stat = ADR_I[AW-1] && (lo == LW'(1));

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign bpush   = commit & WE_I & is_fifo;
  assign bpop    = commit & ~WE_I & is_fifo;
  assign bpop_ok = bpop & ~empty;
  // With one entry left a bus pop takes it and the consumer pop is dropped.
  assign cpop_ok = q_rdy & ~empty & ~(bpop_ok & (cnt_q == CW'(1)));
  assign push_ok = bpush & (~full | cpop_ok);
  assign stat_wr = commit & WE_I & is_stat;
  assign rp_b    = rp_q + PW'(cpop_ok);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(bpop_ok) - CW'(cpop_ok);

  always_comb begin
    stat         = '0;
    stat[CW-1:0] = cnt_q;
    stat[16]     = empty;
    stat[17]     = full;
    stat[18]     = ovf_q;
    stat[19]     = unf_q;
  end

  always_comb begin
    rdata = '0;
    if (!WE_I) begin
      if (is_reg)                 rdata = regs_q[lo];
      else if (is_fifo && !empty) rdata = mem_q[rp_b];
      else if (is_stat)           rdata = stat;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      dat_q   <= '0;
      regs_q  <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dat_q   <= commit ? rdata : '0;
      if (commit && WE_I && is_reg)
        for (int b = 0; b < DW/8; b++)
          if (SEL_I[b]) regs_q[lo][b*8 +: 8] <= DAT_I[b*8 +: 8];
      rp_q    <= rp_q + PW'(bpop_ok) + PW'(cpop_ok);
      wp_q    <= wp_q + PW'(push_ok);
      cnt_q   <= cnt_d;
      ovf_q   <= stat_wr ? 1'b0 : (ovf_q | (bpush & ~push_ok));
      unf_q   <= stat_wr ? 1'b0 : (unf_q | (bpop & empty));
      irq_q   <= ovf_q | unf_q;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push_ok) mem_q[wp_q] <= DAT_I;
  end

  assign ACK_O = (state_q == S_ACK);
  assign DAT_O = dat_q;
  assign q_vld = ~empty;
  assign q_dat = empty ? '0 : mem_q[rp_q];
  assign irq   = irq_q;
endmodule

// File: tb/tb_m_wishbonereg_bank.sv
// Bench for m_wishbonereg_bank: a WAIT=0 instance checked by vector table,
// queue model and random traffic, plus a WAIT=3 instance for timing cases.
module tb_m_wishbonereg_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stb0 = 0, we0 = 0, rdy0 = 0;
  logic [2:0]  adr0 = 0;
  logic [3:0]  sel0 = 0;
  logic [31:0] dat0 = 0, dato0, qd0;
  logic        ack0, qv0, irq0;

  logic        stb1 = 0, we1 = 0, rdy1 = 0;
  logic [2:0]  adr1 = 0;
  logic [3:0]  sel1 = 0;
  logic [31:0] dat1 = 0, dato1, qd1;
  logic        ack1, qv1, irq1;

  m_wishbonereg_bank #(.NREG(4), .DW(32), .WAIT(0), .DEPTH(8)) u0 (
    .CLK_I(clk), .RST_I(rst), .STB_I(stb0), .WE_I(we0), .ADR_I(adr0), .SEL_I(sel0),
    .DAT_I(dat0), .ACK_O(ack0), .DAT_O(dato0), .q_dat(qd0), .q_vld(qv0),
    .q_rdy(rdy0), .irq(irq0));

  m_wishbonereg_bank #(.NREG(4), .DW(32), .WAIT(3), .DEPTH(8)) u1 (
    .CLK_I(clk), .RST_I(rst), .STB_I(stb1), .WE_I(we1), .ADR_I(adr1), .SEL_I(sel1),
    .DAT_I(dat1), .ACK_O(ack1), .DAT_O(dato1), .q_dat(qd1), .q_vld(qv1),
    .q_rdy(rdy1), .irq(irq1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model of the WAIT=0 instance
  logic [31:0] mreg [4];
  logic [31:0] mq [$];
  bit          movf, munf;

  function automatic logic [31:0] mstat();
    logic [31:0] s;
    s     = 32'(mq.size());
    s[16] = (mq.size() == 0);
    s[17] = (mq.size() == 8);
    s[18] = movf;
    s[19] = munf;
    return s;
  endfunction

  function automatic logic [31:0] mop(input logic we, input logic [2:0] a,
                                      input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    if (!a[2]) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mreg[a[1:0]][b*8 +: 8] = d[b*8 +: 8];
      end else r = mreg[a[1:0]];
    end else if (a[1:0] == 2'd0) begin
      if (we) begin
        if (mq.size() < 8) mq.push_back(d);
        else movf = 1;
      end else if (mq.size() > 0) r = mq.pop_front();
      else munf = 1;
    end else if (a[1:0] == 2'd1) begin
      if (we) begin movf = 0; munf = 0; end
      else r = mstat();
    end
    return r;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mq.delete();
    movf = 0;
    munf = 0;
  endfunction

  task automatic bus0(input logic we, input logic [2:0] a, input logic [3:0] sel,
                      input logic [31:0] d, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    stb0 = 1; we0 = we; adr0 = a; sel0 = sel; dat0 = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack0 && lat < 20);
    rd = dato0;
    stb0 = 0; we0 = 0;
    chk("lat0", 32'(lat), 32'd1);
  endtask

  task automatic op0(input logic we, input logic [2:0] a, input logic [3:0] sel,
                     input logic [31:0] d);
    logic [31:0] rd, ex;
    bus0(we, a, sel, d, rd);
    ex = mop(we, a, sel, d);
    if (!we) chk("rd0", rd, ex);
  endtask

  task automatic bus1(input logic we, input logic [2:0] a, input logic [3:0] sel,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    @(negedge clk);
    stb1 = 1; we1 = we; adr1 = a; sel1 = sel; dat1 = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack1 && lat < 30);
    rd = dato1;
    stb1 = 0; we1 = 0;
  endtask

  // Consumer port: k pop attempts, head checked against the model before each
  task automatic drain(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("q_vld", 32'(qv0), 32'(mq.size() != 0));
      chk("q_dat", qd0, (mq.size() != 0) ? mq[0] : 32'h0);
      rdy0 = 1;
      @(negedge clk);
      rdy0 = 0;
      if (mq.size() != 0) void'(mq.pop_front());
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        rchk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int acks [$];
    int nack, prev;

    tbl[0]  = '{1'b1, 3'd1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'd1, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 3'd0, 4'hF, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 3'd0, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 3'd0, 4'hF, 32'h0,        1'b1, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 3'd6, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 3'd6, 4'hF, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b0, 3'd7, 4'hF, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 3'd2, 4'hF, 32'h0,        1'b1, 32'h0};
    tbl[9]  = '{1'b1, 3'd3, 4'h8, 32'h12345678, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 3'd3, 4'hF, 32'h0,        1'b1, 32'h12000000};
    tbl[11] = '{1'b0, 3'd5, 4'hF, 32'h0,        1'b1, 32'h00010000};

    mreset();
    stb0 = 1;
    repeat (2) @(negedge clk);
    chk("rst ack0", 32'(ack0), 0);
    chk("rst dat0", dato0, 0);
    chk("rst qv0", 32'(qv0), 0);
    chk("rst qd0", qd0, 0);
    chk("rst irq0", 32'(irq0), 0);
    chk("rst ack1", 32'(ack1), 0);
    chk("rst dat1", dato1, 0);
    stb0 = 0;
    rst = 1;

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ex;
      bus0(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd);
      ex = mop(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat);
      if (tbl[i].rchk) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // FIFO overflow, sticky clear, in-order drain
    for (int i = 0; i < 9; i++) op0(1, 3'd4, 4'hF, 32'hA000_0000 + 32'(i));
    bus0(0, 3'd5, 4'hF, 0, rd); void'(mop(0, 3'd5, 4'hF, 0));
    chk("stat full", rd, 32'h0006_0008);
    @(negedge clk);
    chk("irq ovf", 32'(irq0), 1);
    op0(1, 3'd5, 4'hF, 32'hFFFFFFFF);
    bus0(0, 3'd5, 4'hF, 0, rd); void'(mop(0, 3'd5, 4'hF, 0));
    chk("stat clr", rd, 32'h0002_0008);
    @(negedge clk);
    chk("irq clr", 32'(irq0), 0);
    drain(9);
    chk("drained", 32'(qv0), 0);

    // Underflow on empty bus pop
    bus0(0, 3'd4, 4'hF, 0, rd); void'(mop(0, 3'd4, 4'hF, 0));
    chk("pop empty", rd, 0);
    bus0(0, 3'd5, 4'hF, 0, rd); void'(mop(0, 3'd5, 4'hF, 0));
    chk("stat unf", rd, 32'h0009_0000);

    // Bus push with same-edge consumer pop at count 3
    for (int i = 1; i <= 3; i++) op0(1, 3'd4, 4'hF, 32'h100 * i);
    @(negedge clk);
    @(negedge clk);
    chk("head", qd0, 32'h100);
    stb0 = 1; we0 = 1; adr0 = 3'd4; dat0 = 32'h400; rdy0 = 1;
    @(negedge clk);
    chk("ack push+pop", 32'(ack0), 1);
    stb0 = 0; we0 = 0; rdy0 = 0;
    void'(mq.pop_front());
    mq.push_back(32'h400);
    bus0(0, 3'd5, 4'hF, 0, rd); void'(mop(0, 3'd5, 4'hF, 0));
    chk("count kept", rd, 32'h0008_0003);

    // Bus pop and consumer pop at count 1: bus wins
    op0(0, 3'd4, 4'hF, 0);
    op0(0, 3'd4, 4'hF, 0);
    @(negedge clk);
    @(negedge clk);
    stb0 = 1; we0 = 0; adr0 = 3'd4; rdy0 = 1;
    @(negedge clk);
    chk("ack last pop", 32'(ack0), 1);
    chk("bus pop wins", dato0, 32'h400);
    stb0 = 0; rdy0 = 0;
    void'(mq.pop_front());
    @(negedge clk);
    chk("q_vld drop", 32'(qv0), 0);
    op0(0, 3'd5, 4'hF, 0);
    op0(1, 3'd5, 4'hF, 0);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 9) < 4) ? 3'd4 : 3'($urandom_range(0, 7));
      op0(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      @(negedge clk);
      chk("irq", 32'(irq0), 32'(movf | munf));
      if ($urandom_range(0, 7) == 0) drain($urandom_range(1, 4));
    end

    // WAIT=3 instance: latency
    bus1(1, 3'd2, 4'hF, 32'h5A5A5A5A, rd, lat);
    chk("w3 wr lat", 32'(lat), 4);
    bus1(0, 3'd2, 4'hF, 0, rd, lat);
    chk("w3 rd lat", 32'(lat), 4);
    chk("w3 rd dat", rd, 32'h5A5A5A5A);

    // Back-to-back with STB held high
    @(negedge clk);
    stb1 = 1; we1 = 0; adr1 = 3'd2;
    prev = 0;
    nack = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack1) begin
        acks.push_back(c);
        if (prev != 0) nack++;
      end
      prev = ack1 ? c : 0;
    end
    stb1 = 0;
    chk("b2b count", 32'(acks.size()), 3);
    chk("b2b consec", 32'(nack), 0);
    if (acks.size() == 3) begin
      chk("b2b 1st", 32'(acks[0]), 4);
      chk("b2b gap1", 32'(acks[1] - acks[0]), 5);
      chk("b2b gap2", 32'(acks[2] - acks[1]), 5);
    end

    // STB dropped during WAIT: abandoned write
    repeat (2) @(negedge clk);
    stb1 = 1; we1 = 1; adr1 = 3'd3; sel1 = 4'hF; dat1 = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    stb1 = 0; we1 = 0;
    nack = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack1) nack++;
    end
    chk("abandon ack", 32'(nack), 0);
    bus1(0, 3'd3, 4'hF, 0, rd, lat);
    chk("abandon r3", rd, 0);

    // Reset during WAIT of a write
    @(negedge clk);
    stb1 = 1; we1 = 1; adr1 = 3'd1; sel1 = 4'hF; dat1 = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst mid ack", 32'(ack1), 0);
    chk("rst mid dat", dato1, 0);
    chk("rst mid qv0", 32'(qv0), 0);
    @(negedge clk);
    chk("rst hold ack", 32'(ack1), 0);
    stb1 = 0; we1 = 0;
    @(negedge clk);
    rst = 1;
    mreset();
    bus1(0, 3'd1, 4'hF, 0, rd, lat);
    chk("rst r1", rd, 0);
    chk("rst r1 lat", 32'(lat), 4);
    op0(0, 3'd1, 4'hF, 0);
    op0(0, 3'd5, 4'hF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_wishbonereg_bank.md
Name: m_wishbonereg_bank

Overview:
- Parametrised successor to the single wishbone test register used in the simulation tops.
- Contains NREG byte-lane-writable registers, a push/pop FIFO mailbox and a status/sticky-error register.
- ACK latency is programmable, so core wait-state handling can be exercised.
- Sits behind the top-level STB_I address decode; the FIFO drains to a testbench-side consumer port (console/trace output).

Parameters:
- NREG, 4: number of general registers; power of 2, 2..16.
- DW, 32: data width; multiple of 8, >= 24.
- WAIT, 0: extra wait cycles before ACK_O; 0..7.
- DEPTH, 8: FIFO entries; power of 2, 2..64.
- Derived: AW = clog2(NREG)+1; CW = clog2(DEPTH)+1.

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- STB_I  in  1  strobe, already address-decoded by the parent.
- WE_I  in  1  write enable.
- ADR_I  in  AW  word index.
- SEL_I  in  DW/8  byte lane selects.
- DAT_I  in  DW  write data.
- ACK_O  out  1  one-cycle acknowledge.
- DAT_O  out  DW  read data; valid while ACK_O=1, else 0.
- q_dat  out  DW  FIFO head; 0 when empty.
- q_vld  out  1  FIFO non-empty.
- q_rdy  in  1  consumer pop; pop occurs when q_vld & q_rdy at an edge.
- irq  out  1  overflow | underflow sticky.

Behaviour:
- Reset (RST_I=0, asynchronous): ACK_O=0, DAT_O=0, registers=0, FIFO empty, q_vld=0, q_dat=0, stickies=0, irq=0, FSM=IDLE. Reset aborts any transaction in flight; no write commits.
- Address map:
  - ADR_I[AW-1]=0: register r[ADR_I[AW-2:0]], read/write.
  - ADR_I[AW-1]=1, low bits 0: FIFO port; write pushes, read pops.
  - ADR_I[AW-1]=1, low bits 1: status register.
  - ADR_I[AW-1]=1, other low bits: read 0, writes ignored, ACK still given.
- Status register: bits[CW-1:0]=count, bit16=empty, bit17=full, bit18=overflow, bit19=underflow, all other bits 0. Any write clears both stickies.
- FSM:
  - IDLE --STB_I--> WAIT if WAIT>0, else ACK.
  - WAIT counts WAIT cycles --> ACK.
  - ACK --> IDLE unconditionally.
- ACK_O is registered and high only in the ACK state. Latency from first STB_I-high edge to ACK_O high is WAIT+1 cycles.
- With STB_I held high back-to-back, an ACK occurs every WAIT+2 cycles. ACK_O is never high on two consecutive cycles.
- STB_I dropping during WAIT abandons the cycle: return to IDLE, no ACK, no side effect.
- Commit point: all side effects (register write, push, pop, sticky clear) occur on the edge that enters ACK. DAT_O is captured on that same edge.
- Register writes: only lanes with SEL_I[i]=1 update byte i. SEL_I is ignored for FIFO and status accesses.
- Push when full: data dropped, overflow set.
- Bus pop when empty: DAT_O=0, underflow set.
- Simultaneous bus push and consumer pop in the same edge: both occur, count unchanged. A push to a full FIFO with a same-edge consumer pop is accepted.
- Simultaneous bus pop and consumer pop with count=1: the bus pop wins, the consumer pop is suppressed, and q_vld drops.
- Pointers wrap modulo DEPTH. Count saturates neither way because it is range-checked.
- irq is registered, updating one cycle after the causing edge.

Test Plan:
- Reset release, WAIT=0: write r1=0xDEADBEEF with SEL=1111, read back -> ACK_O exactly 1 cycle after STB_I, DAT_O=0xDEADBEEF; all outputs 0 during reset.
- Byte lanes: r0=0x11223344, then write 0xAABBCCDD with SEL=0101 -> read 0x11BB33DD.
- WAIT=3: single read -> ACK_O on the 4th edge. STB_I held high for 3 transactions -> ACKs 5 cycles apart. STB_I dropped after 2 cycles -> no ACK, state unchanged.
- FIFO with DEPTH=8, q_rdy=0: push 9 words -> status count=8, full=1, overflow=1, irq=1. Write status -> overflow=0, irq=0. Raise q_rdy -> first 8 words drained in order, q_vld=0.
- Empty FIFO bus pop -> DAT_O=0, underflow=1. Push plus consumer pop on the same edge at count=3 -> count stays 3.
- Assert RST_I low during the WAIT state of a write -> no ACK, target register remains 0 after release.
